// File: rtl/addsub_nibble_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice, LS nibble first.
// Result valid WIDTH/4 cycles after accept; DONE holds until out_ready, no same-cycle accept/retire.
`timescale 1ns/1ps
module addsub_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             sub_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic             last;
  logic [3:0]       sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0]       sl_c;
  logic [WIDTH-1:0] res_fin;

  // 4-bit carry-lookahead slice; sl_c[3] is the carry into the slice MSB
  always_comb begin
    sl_a    = a_q[3:0];
    sl_b    = b_q[3:0];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c[0] = carry_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_s    = sl_p ^ sl_c[3:0];
    res_fin = {sl_s, res_q[WIDTH-1:4]};
  end

  assign last = (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = src1;
      b_d     = sub_flag ? ~src2 : src2;
      carry_d = sub_flag;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = {4'b0, a_q[WIDTH-1:4]};
      b_d     = {4'b0, b_q[WIDTH-1:4]};
      res_d   = res_fin;
      carry_d = sl_c[4];
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        sum_d  = res_fin;
        cout_d = sl_c[4];
        ovf_d  = sl_c[3] ^ sl_c[4];
        zero_d = (res_fin == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Bench for addsub_nibble_seq (WIDTH=16): directed corner cases, backpressure, back-to-back,
// mid-operation reset and random operations against an integer-arithmetic reference.
`timescale 1ns/1ps
module tb_addsub_nibble_seq;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sub_flag, out_valid, out_ready;
  logic [W-1:0] src1, src2, sum;
  logic         carry_out, overflow, zero, busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  addsub_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .sub_flag(sub_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views of the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= 65536);
    end
    r = W'(ur & 32'hFFFF);
    v = (sr > 32767) || (sr < -32768);
    z = (r == '0);
  endtask

  // All tasks start and end 1ns after a rising edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    check("in_ready_before_accept", in_ready, 1);
    src1 = a; src2 = b; sub_flag = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic ir_bad);
    lat = 0;
    ir_bad = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] r;
    logic c, v, z;
    model(a, b, s, r, c, v, z);
    check({tag, "_sum"}, sum, r);
    check({tag, "_carry"}, carry_out, c);
    check({tag, "_ovf"}, overflow, v);
    check({tag, "_zero"}, zero, z);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_out_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int stall);
    int lat;
    logic ir_bad;
    issue(a, b, s);
    wait_result(lat, ir_bad);
    check({tag, "_latency"}, lat, NIB);
    check({tag, "_in_ready_low"}, ir_bad, 0);
    repeat (stall) begin @(posedge clk); #1; end
    check({tag, "_out_valid"}, out_valid, 1);
    check_result(tag, a, b, s);
    retire();
  endtask

  initial begin
    logic [W-1:0] er;
    logic ec, ev, ez;
    logic [W-1:0] ba[3], bb[3];
    logic bs[3];
    int acc[3];
    int idx, nres, lat;
    logic ir_bad;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; sub_flag = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {sum, carry_out, overflow, zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add",      16'h1234, 16'h4321, 1'b0, 0);
    do_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 0);
    do_op("borrow",   16'h0003, 16'h0005, 1'b1, 0);
    do_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 0);
    check("add_literal", sum, 16'h7FFF);

    // Backpressure: DONE held while inputs churn
    issue(16'hA5A5, 16'h1111, 1'b1);
    wait_result(lat, ir_bad);
    check("bp_latency", lat, NIB);
    model(16'hA5A5, 16'h1111, 1'b1, er, ec, ev, ez);
    for (int i = 0; i < 5; i++) begin
      src1 = W'($urandom); src2 = W'($urandom); in_valid = $urandom_range(0, 1) != 0;
      sub_flag = $urandom_range(0, 1) != 0;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {sum, carry_out, overflow, zero}, {er, ec, ev, ez});
    end
    in_valid = 1'b0;
    retire();
    @(posedge clk); #1;
    check("bp_no_accept", busy, 0);
    check("bp_keep_result", {sum, carry_out, overflow, zero}, {er, ec, ev, ez});

    // Back-to-back with in_valid and out_ready held high
    ba[0] = 16'h0F0F; bb[0] = 16'h00F1; bs[0] = 1'b0;
    ba[1] = 16'h1000; bb[1] = 16'h2000; bs[1] = 1'b1;
    ba[2] = 16'h8001; bb[2] = 16'h8001; bs[2] = 1'b0;
    idx = 0; nres = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int t = 0; t < 80 && nres < 3; t++) begin
      if (out_valid && nres < idx) begin
        check_result("b2b", ba[nres], bb[nres], bs[nres]);
        nres++;
      end
      if (in_ready && idx < 3) begin
        src1 = ba[idx]; src2 = bb[idx]; sub_flag = bs[idx];
        acc[idx] = cyc + 1;
        idx++;
      end else if (!in_ready && idx == 3) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_spacing_01", acc[1] - acc[0], NIB + 2);
    check("b2b_spacing_12", acc[2] - acc[1], NIB + 2);
    @(posedge clk); #1;

    // Asynchronous reset while RUN is mid-way (cnt==2)
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outputs", {sum, carry_out, overflow, zero}, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 0);
    check("post_rst_literal", sum, 16'h0100);

    for (int i = 0; i < 25; i++) begin
      do_op("rand", W'($urandom), W'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
